// File: rtl/alu_frame_loader_if.sv
// ============================================================================
// Module   : alu_frame_loader_if
// Brief    : Nibble-stream, ALU-operand and result-readout signals of the frame loader
// Revision : 1.0
// ============================================================================
`default_nettype none

interface alu_frame_loader_if;
    logic       ena;
    logic       load;
    logic [3:0] din;
    logic       rd_ack;
    logic [7:0] alu_result;
    logic       alu_cout;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [2:0] alu_sel;
    logic [7:0] dout;
    logic       cout_q;
    logic       res_valid;
    logic       busy;
    logic       err;

    // Host, consumer and ALU side: everything the loader does not drive
    modport master (
        output ena, load, din, rd_ack, alu_result, alu_cout,
        input  alu_a, alu_b, alu_sel, dout, cout_q, res_valid, busy, err
    );

    modport slave (
        input  ena, load, din, rd_ack, alu_result, alu_cout,
        output alu_a, alu_b, alu_sel, dout, cout_q, res_valid, busy, err
    );
endinterface

`default_nettype wire

// File: rtl/alu_frame_loader.sv
// ============================================================================
// Module   : alu_frame_loader
// Brief    : Assembles 8-bit A/B and 3-bit opcode from a 5-nibble frame, holds them
//            on the ALU, captures result/carry and holds them until acknowledged
// Revision : 1.0
// ============================================================================
`default_nettype none

module alu_frame_loader (
    input  wire logic          clk,
    input  wire logic          rst,
    alu_frame_loader_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_EXEC = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [2:0] C_CNT_FIRST = 3'd1;
    localparam logic [2:0] C_CNT_LAST  = 3'd4;

    state_t     r_state, w_state_nxt;
    logic [2:0] r_cnt,   w_cnt_nxt;
    logic [7:0] r_a,     w_a_nxt;
    logic [7:0] r_b,     w_b_nxt;
    logic [2:0] r_sel,   w_sel_nxt;
    logic [7:0] r_dout,  w_dout_nxt;
    logic       r_cout,  w_cout_nxt;
    logic       r_valid, w_valid_nxt;
    logic       r_err,   w_err_nxt;

    logic       w_hdr_ok;

    assign w_hdr_ok = ~bus.din[3];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= 3'd0;
            r_a     <= 8'd0;
            r_b     <= 8'd0;
            r_sel   <= 3'd0;
            r_dout  <= 8'd0;
            r_cout  <= 1'b0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_a     <= w_a_nxt;
            r_b     <= w_b_nxt;
            r_sel   <= w_sel_nxt;
            r_dout  <= w_dout_nxt;
            r_cout  <= w_cout_nxt;
            r_valid <= w_valid_nxt;
            r_err   <= w_err_nxt;
        end
    end

    // Everything holds by default; ena=0 therefore freezes the whole block.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_a_nxt     = r_a;
        w_b_nxt     = r_b;
        w_sel_nxt   = r_sel;
        w_dout_nxt  = r_dout;
        w_cout_nxt  = r_cout;
        w_valid_nxt = r_valid;
        w_err_nxt   = r_err;

        if (bus.ena) begin
            unique case (r_state)
                ST_IDLE: begin
                    if (bus.load) begin
                        if (w_hdr_ok) begin
                            w_sel_nxt   = bus.din[2:0];
                            w_cnt_nxt   = C_CNT_FIRST;
                            w_err_nxt   = 1'b0;
                            w_state_nxt = ST_LOAD;
                        end else begin
                            w_err_nxt   = 1'b1;
                        end
                    end
                end

                ST_LOAD: begin
                    if (bus.load) begin
                        unique case (r_cnt)
                            3'd1:    w_a_nxt[3:0] = bus.din;
                            3'd2:    w_a_nxt[7:4] = bus.din;
                            3'd3:    w_b_nxt[3:0] = bus.din;
                            default: w_b_nxt[7:4] = bus.din;
                        endcase
                        if (r_cnt == C_CNT_LAST) begin
                            w_state_nxt = ST_EXEC;
                        end else begin
                            w_cnt_nxt   = r_cnt + 3'd1;
                        end
                    end
                end

                ST_EXEC: begin
                    w_dout_nxt  = bus.alu_result;
                    w_cout_nxt  = bus.alu_cout;
                    w_valid_nxt = 1'b1;
                    w_state_nxt = ST_DONE;
                    if (bus.load) begin
                        w_err_nxt = 1'b1;
                    end
                end

                ST_DONE: begin
                    // A new header outranks the acknowledge; the old result stays on dout.
                    if (bus.load) begin
                        w_valid_nxt = 1'b0;
                        if (w_hdr_ok) begin
                            w_sel_nxt   = bus.din[2:0];
                            w_cnt_nxt   = C_CNT_FIRST;
                            w_err_nxt   = 1'b0;
                            w_state_nxt = ST_LOAD;
                        end else begin
                            w_err_nxt   = 1'b1;
                            w_state_nxt = ST_IDLE;
                        end
                    end else if (bus.rd_ack) begin
                        w_valid_nxt = 1'b0;
                        w_state_nxt = ST_IDLE;
                    end
                end

                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    assign bus.alu_a     = r_a;
    assign bus.alu_b     = r_b;
    assign bus.alu_sel   = r_sel;
    assign bus.dout      = r_dout;
    assign bus.cout_q    = r_cout;
    assign bus.res_valid = r_valid;
    assign bus.err       = r_err;
    assign bus.busy      = (r_state == ST_LOAD) || (r_state == ST_EXEC);

endmodule

`default_nettype wire

// File: tb/tb_alu_frame_loader.sv
// ============================================================================
// Module   : tb_alu_frame_loader
// Brief    : Scoreboard bench for alu_frame_loader with a behavioural 8-bit ALU
// Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_alu_frame_loader;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    alu_frame_loader_if ifc ();

    alu_frame_loader dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    // Behavioural ALU: returns {carry, result}
    function automatic logic [8:0] alu_f(input logic [2:0] s, input logic [7:0] a, input logic [7:0] b);
        case (s)
            3'd0:    alu_f = {1'b0, a} + {1'b0, b};
            3'd1:    alu_f = {1'b0, a} - {1'b0, b};
            3'd2:    alu_f = {1'b0, a & b};
            3'd3:    alu_f = {1'b0, a | b};
            3'd4:    alu_f = {1'b0, a ^ b};
            3'd5:    alu_f = {1'b0, ~a};
            3'd6:    alu_f = {a, 1'b0};
            default: alu_f = {a[0], 1'b0, a[7:1]};
        endcase
    endfunction

    assign {ifc.alu_cout, ifc.alu_result} = alu_f(ifc.alu_sel, ifc.alu_a, ifc.alu_b);

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [8:0] exp_q[$];
    logic [8:0] mon_exp;
    logic       prev_valid = 1'b0;

    // Monitor: every rising res_valid is one capture to match against the queue
    always @(negedge clk) begin
        if (ifc.res_valid && !prev_valid) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL capture_unexpected: got cout=%b dout=%h, nothing expected", ifc.cout_q, ifc.dout);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({ifc.cout_q, ifc.dout} !== mon_exp) begin
                    n_fail++;
                    $display("FAIL capture_value: got cout=%b dout=%h, expected cout=%b dout=%h",
                             ifc.cout_q, ifc.dout, mon_exp[8], mon_exp[7:0]);
                end
            end
        end
        prev_valid = ifc.res_valid;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Presents one nibble; optional ena=0 stall while load is held shows it is ignored
    task automatic nib(input logic [3:0] d, input int stall);
        ifc.load = 1'b1;
        ifc.din  = d;
        if (stall > 0) begin
            ifc.ena = 1'b0;
            repeat (stall) tick();
            ifc.ena = 1'b1;
        end
        tick();
        ifc.load = 1'b0;
        ifc.din  = 4'($urandom);
    endtask

    // Sends frame nibbles first..last; a frame reaching n4 queues its expected result
    task automatic nibs(input logic [2:0] s, input logic [7:0] a, input logic [7:0] b,
                        input int first, input int last, input int maxgap, input int maxstall);
        logic [3:0] n [5];
        n[0] = {1'b0, s};
        n[1] = a[3:0];
        n[2] = a[7:4];
        n[3] = b[3:0];
        n[4] = b[7:4];
        for (int i = first; i <= last; i++) begin
            if (i > first && maxgap > 0) repeat ($urandom_range(0, maxgap)) tick();
            if (i == 4) exp_q.push_back(alu_f(s, a, b));
            nib(n[i], (maxstall > 0) ? int'($urandom_range(0, maxstall)) : 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] s;
        logic [7:0] a, b;
        int         w;

        ifc.ena    = 1'b1;
        ifc.load   = 1'b0;
        ifc.din    = 4'd0;
        ifc.rd_ack = 1'b0;
        rst        = 1'b1;
        repeat (2) tick();
        rst = 1'b0;

        chk("reset_alu_a",     ifc.alu_a, 0);
        chk("reset_alu_b",     ifc.alu_b, 0);
        chk("reset_alu_sel",   ifc.alu_sel, 0);
        chk("reset_dout",      ifc.dout, 0);
        chk("reset_cout",      ifc.cout_q, 0);
        chk("reset_res_valid", ifc.res_valid, 0);
        chk("reset_busy",      ifc.busy, 0);
        chk("reset_err",       ifc.err, 0);

        // Frame 0,5,A,3,C: A+B = 0xA5+0xC3 = 0x168
        nibs(3'd0, 8'hA5, 8'hC3, 0, 4, 0, 0);
        chk("f1_alu_a", ifc.alu_a, 32'hA5);
        chk("f1_alu_b", ifc.alu_b, 32'hC3);
        chk("f1_busy_exec", ifc.busy, 1);
        chk("f1_valid_exec", ifc.res_valid, 0);
        tick();
        chk("f1_dout", ifc.dout, 32'h68);
        chk("f1_cout", ifc.cout_q, 1);
        chk("f1_valid", ifc.res_valid, 1);
        chk("f1_busy_done", ifc.busy, 0);

        // Acknowledge, then a bad header followed by a good one
        ifc.rd_ack = 1'b1;
        tick();
        ifc.rd_ack = 1'b0;
        chk("ack_valid", ifc.res_valid, 0);
        chk("ack_busy", ifc.busy, 0);
        nib(4'h8, 0);
        chk("badhdr_err", ifc.err, 1);
        chk("badhdr_busy", ifc.busy, 0);
        chk("badhdr_sel", ifc.alu_sel, 0);
        nib(4'h1, 0);
        chk("goodhdr_err", ifc.err, 0);
        chk("goodhdr_busy", ifc.busy, 1);
        chk("goodhdr_sel", ifc.alu_sel, 1);

        // Gapped frame with a 3-cycle ena stall in EXEC: 0x3C-0x15 = 0x27
        nibs(3'd1, 8'h3C, 8'h15, 1, 4, 2, 0);
        ifc.ena = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_hold_valid", ifc.res_valid, 0);
            chk("stall_hold_busy", ifc.busy, 1);
        end
        ifc.ena = 1'b1;
        tick();
        chk("stall_capture_valid", ifc.res_valid, 1);
        chk("stall_capture_dout", ifc.dout, 32'h27);

        // Header and rd_ack together in DONE: the load wins
        ifc.rd_ack = 1'b1;
        nib(4'h2, 0);
        ifc.rd_ack = 1'b0;
        chk("race_valid", ifc.res_valid, 0);
        chk("race_busy", ifc.busy, 1);
        chk("race_sel", ifc.alu_sel, 2);
        chk("race_dout_kept", ifc.dout, 32'h27);
        nibs(3'd2, 8'h5A, 8'h0F, 1, 4, 1, 1);
        tick();
        chk("race_new_capture", ifc.res_valid, 1);
        chk("race_new_dout", ifc.dout, 32'h0A);

        // Load during EXEC is dropped: 0x96^0x3C = 0xAA
        ifc.rd_ack = 1'b1;
        tick();
        ifc.rd_ack = 1'b0;
        nibs(3'd4, 8'h96, 8'h3C, 0, 4, 0, 0);
        ifc.load = 1'b1;
        ifc.din  = 4'hF;
        tick();
        ifc.load = 1'b0;
        chk("execload_err", ifc.err, 1);
        chk("execload_valid", ifc.res_valid, 1);
        chk("execload_dout", ifc.dout, 32'hAA);
        chk("execload_alu_b", ifc.alu_b, 32'h3C);

        // Reset after the third nibble
        ifc.rd_ack = 1'b1;
        tick();
        ifc.rd_ack = 1'b0;
        nibs(3'd3, 8'h11, 8'h22, 0, 2, 0, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_alu_a", ifc.alu_a, 0);
        chk("midrst_alu_b", ifc.alu_b, 0);
        chk("midrst_sel", ifc.alu_sel, 0);
        chk("midrst_dout", ifc.dout, 0);
        chk("midrst_busy", ifc.busy, 0);
        chk("midrst_err", ifc.err, 0);
        chk("midrst_valid", ifc.res_valid, 0);
        nibs(3'd6, 8'h81, 8'h00, 0, 4, 0, 0);
        tick();
        chk("postrst_dout", ifc.dout, 32'h02);
        chk("postrst_cout", ifc.cout_q, 1);

        // Randomised frames with gaps, ignored-load stalls and both DONE exits
        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 4) == 0) begin
                nib({1'b1, 3'($urandom)}, 0);
                chk("rnd_badhdr_err", ifc.err, 1);
            end
            s = 3'($urandom);
            a = 8'($urandom);
            b = 8'($urandom);
            nibs(s, a, b, 0, 4, 2, 2);
            chk("rnd_alu_a", ifc.alu_a, 32'(a));
            chk("rnd_alu_b", ifc.alu_b, 32'(b));
            ifc.ena = 1'b0;
            repeat ($urandom_range(0, 2)) tick();
            ifc.ena = 1'b1;
            w = 0;
            while (!ifc.res_valid && w < 4) begin
                tick();
                w++;
            end
            chk("rnd_capture_seen", ifc.res_valid, 1);
            if ($urandom_range(0, 1) == 1) begin
                ifc.rd_ack = 1'b1;
                tick();
                ifc.rd_ack = 1'b0;
                repeat ($urandom_range(0, 2)) tick();
            end
        end

        repeat (3) tick();
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/alu_frame_loader.md
# alu_frame_loader

Upstream operand sequencer for the 8-bit ALU. The pin-level operand mapping only gives the ALU 3-bit A and 2-bit B. This block removes that limit by assembling full 8-bit A, 8-bit B and a 3-bit opcode from a 4-bit nibble stream. It holds the assembled operands stable on the ALU inputs, registers the ALU's combinational result and carry one cycle later, and holds them for readout until acknowledged.

## Interface
Parameters: none. Frame length is fixed at 5 nibbles; widths are fixed by the ALU.

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  reset, synchronous and active-high; clears all state on a rising edge where it is 1
- ena  in  1  global enable; when 0, all state and outputs are frozen and every other input is ignored
- load  in  1  nibble strobe; din is sampled on every edge where load=1 and ena=1
- din  in  4  frame nibble
- rd_ack  in  1  consumer acknowledge of the held result
- alu_result  in  8  ALU combinational result
- alu_cout  in  1  ALU combinational carry
- alu_a  out  8  registered operand A to the ALU
- alu_b  out  8  registered operand B to the ALU
- alu_sel  out  3  registered opcode to the ALU
- dout  out  8  captured result
- cout_q  out  1  captured carry
- res_valid  out  1  dout/cout_q hold a result not yet acknowledged
- busy  out  1  high in the LOAD and EXEC states
- err  out  1  sticky error flag (bad header or dropped nibble)

## Operation
- Frame format, in order:
  - n0 = {1'b0, sel[2:0]}
  - n1 = A[3:0]
  - n2 = A[7:4]
  - n3 = B[3:0]
  - n4 = B[7:4]
- A header with din[3]=1 is invalid.
- States:
  - IDLE: waiting for a header
  - LOAD: nibble counter cnt runs 1..4
  - EXEC: one cycle; the ALU settles on the stable operands
  - DONE: result held
- IDLE, load with valid header:
  - alu_sel <= din[2:0]; cnt <= 1; err <= 0; go to LOAD.
- IDLE, load with invalid header:
  - err <= 1; stay in IDLE; alu_* unchanged.
- LOAD, load:
  - Write the nibble into the alu_a/alu_b slice selected by cnt.
  - If cnt==4, go to EXEC; otherwise cnt <= cnt+1.
- LOAD with no load: hold the state; there is no timeout.
- EXEC:
  - dout <= alu_result; cout_q <= alu_cout; res_valid <= 1; go to DONE.
  - A load in EXEC is dropped and sets err <= 1.
- DONE, rd_ack=1 and load=0: res_valid <= 0; go to IDLE.
- DONE, load=1 (regardless of rd_ack): treat din as a header, exactly as in IDLE.
  - res_valid <= 0 on the same edge.
  - dout/cout_q keep their old values until the next capture.
  - An invalid header sets err, drops res_valid, and goes to IDLE.
- rd_ack outside DONE: ignored.
- alu_a, alu_b and alu_sel change only on accepted nibbles. They stay stable from the n4 edge through EXEC and DONE, so the combinational ALU always sees settled operands.
- Unfilled operand bytes retain their previous frame's values until overwritten. A full frame always overwrites all 16 bits.

## Timing
- Reset values: alu_a, alu_b, alu_sel, dout, cout_q, res_valid, busy and err are all 0; state is IDLE; cnt is 0.
- Reset mid-frame or in DONE discards everything; the next edge starts from IDLE.
- Loading: one nibble per accepted edge. Back-to-back loads are allowed; gaps are allowed.
- Latency, with edge E as the n4 edge:
  - Operands are valid after E.
  - dout/cout_q/res_valid are updated at E+1.
  - The earliest next header is accepted at E+2, which is the first DONE cycle.
- busy is 1 from the edge that accepts the header through the EXEC cycle, and falls with the capture edge.
- rd_ack is honoured starting from the first cycle that res_valid=1.
- Simultaneous load and rd_ack in DONE: load wins.
- ena=0 for any number of cycles: no state change, even in EXEC. Capture happens on the first edge with ena=1.
- rst has priority over ena.

## Test plan
- Reset then frame 0,5,A,3,C with the bench ALU modelling sel 000 as A+B:
  - alu_a=0xA5, alu_b=0xC3 after the 5th edge.
  - One edge later: dout=0x68, cout_q=1, res_valid=1, busy=0.
- Header 0x8 in IDLE: err=1, state stays IDLE. Then a valid header 0x1 clears err and busy=1.
- Frame split with idle gaps and an ena=0 stall of 3 cycles during EXEC: capture is delayed exactly 3 cycles, and the value matches the gapless case.
- In DONE, drive rd_ack and a load of 0x2 on the same cycle: res_valid=0, busy=1, alu_sel=2, dout unchanged. Completing the frame yields a new capture.
- Load asserted during EXEC: the nibble is dropped, err=1, and the captured result is unaffected.
- Assert rst after the 3rd nibble: all outputs are 0 next cycle. A fresh 5-nibble frame then produces a correct result.
